pal_timing: RTL

PAL raster timing scheduler for the composite-video test path. Runs on the 70 ns pixel clock and sequences the sample generator that drives the DAC, telling it on every pixel clock whether to output sync tip, blanking, colour burst or active picture. Generates the full 625-line interlaced frame: equalizing pulses, broad pulses, burst blanking and active-line gating. Line and field counters are exposed for pattern addressing.

---
 rtl/pal_timing.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pal_timing.sv
// PAL raster timing scheduler: walks the 625-line interlaced raster one
// position per enabled pixel clock and tells the DAC sample generator which
// level to emit (sync tip, blanking, burst, active picture). Every output is
// registered and decoded from the position being entered on the same edge,
// so flags always describe the hcount/line shown alongside them.
module pal_timing #(
    parameter logic [9:0] LINE_LEN     = 10'd914,
    parameter logic [9:0] HSYNC_LEN    = 10'd67,
    parameter logic [9:0] EQ_LEN       = 10'd34,
    parameter logic [9:0] BURST_START  = 10'd80,
    parameter logic [9:0] BURST_LEN    = 10'd32,
    parameter logic [9:0] ACTIVE_START = 10'd150,
    parameter logic [9:0] ACTIVE_LEN   = 10'd743
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] hcount,
    output logic [9:0] line,
    output logic       field,
    output logic       sync,
    output logic       blank,
    output logic       burst,
    output logic       active,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [9:0] HALF       = LINE_LEN >> 1;
    localparam logic [9:0] BROAD_LEN  = HALF - HSYNC_LEN;
    localparam logic [9:0] BURST_END  = BURST_START + BURST_LEN;
    localparam logic [9:0] ACTIVE_END = ACTIVE_START + ACTIVE_LEN;
    localparam logic [9:0] LAST_LINE  = 10'd625;

    typedef enum logic [1:0] {
        PT_NONE   = 2'd0,
        PT_NORMAL = 2'd1,
        PT_EQ     = 2'd2,
        PT_BROAD  = 2'd3
    } pulse_t;

    // Pulse type of the first half of line l.
    function automatic pulse_t first_half_type(input logic [9:0] l);
        if (l <= 10'd3)        return PT_BROAD;
        else if (l <= 10'd5)   return PT_EQ;
        else if (l <= 10'd310) return PT_NORMAL;
        else if (l <= 10'd313) return PT_EQ;
        else if (l <= 10'd315) return PT_BROAD;
        else if (l <= 10'd318) return PT_EQ;
        else if (l <= 10'd623) return PT_NORMAL;
        else                   return PT_EQ;
    endfunction

    // Pulse type of the second half of line l.
    function automatic pulse_t second_half_type(input logic [9:0] l);
        if (l <= 10'd2)        return PT_BROAD;
        else if (l <= 10'd5)   return PT_EQ;
        else if (l <= 10'd310) return PT_NONE;
        else if (l <= 10'd312) return PT_EQ;
        else if (l <= 10'd315) return PT_BROAD;
        else if (l <= 10'd317) return PT_EQ;
        else if (l <= 10'd622) return PT_NONE;
        else                   return PT_EQ;
    endfunction

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] line_q, line_d;
    logic       field_q, field_d;
    logic       sync_q, sync_d;
    logic       blank_q, blank_d;
    logic       burst_q, burst_d;
    logic       active_q, active_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    logic       second_half;
    logic [9:0] offset;
    pulse_t     pt;
    logic       active_line;
    logic       burst_line;

    // Next position and the flags decoded from it; en low parks the raster
    // at the last position of the frame so that re-enabling starts at (1, 0).
    always_comb begin
        hcount_d      = LINE_LEN - 10'd1;
        line_d        = LAST_LINE;
        field_d       = 1'b1;
        sync_d        = 1'b0;
        blank_d       = 1'b1;
        burst_d       = 1'b0;
        active_d      = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        second_half   = 1'b0;
        offset        = '0;
        pt            = PT_NONE;
        active_line   = 1'b0;
        burst_line    = 1'b0;

        if (en) begin
            if (hcount_q == LINE_LEN - 10'd1) begin
                hcount_d = '0;
                line_d   = (line_q == LAST_LINE) ? 10'd1 : line_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
                line_d   = line_q;
            end

            field_d = field_q;
            if (line_d == 10'd1 && hcount_d == 10'd0)
                field_d = 1'b0;
            else if (line_d == 10'd313 && hcount_d == HALF)
                field_d = 1'b1;

            second_half = (hcount_d >= HALF);
            offset      = second_half ? hcount_d - HALF : hcount_d;
            pt          = second_half ? second_half_type(line_d) : first_half_type(line_d);

            case (pt)
                PT_NORMAL: sync_d = !second_half && (hcount_d < HSYNC_LEN);
                PT_EQ:     sync_d = (offset < EQ_LEN);
                PT_BROAD:  sync_d = (offset < BROAD_LEN);
                default:   sync_d = 1'b0;
            endcase

            active_line = (line_d >= 10'd23 && line_d <= 10'd310) ||
                          (line_d >= 10'd336 && line_d <= 10'd622);
            burst_line  = (line_d >= 10'd7 && line_d <= 10'd310) ||
                          (line_d >= 10'd320 && line_d <= 10'd622);

            active_d      = active_line && (hcount_d >= ACTIVE_START) && (hcount_d < ACTIVE_END);
            blank_d       = !active_d;
            burst_d       = burst_line && (hcount_d >= BURST_START) && (hcount_d < BURST_END);
            line_start_d  = (hcount_d == 10'd0);
            frame_start_d = (hcount_d == 10'd0) && (line_d == 10'd1);
        end
    end

    // Position and flag registers; reset forces the park values at once.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_q      <= LINE_LEN - 10'd1;
            line_q        <= LAST_LINE;
            field_q       <= 1'b1;
            sync_q        <= 1'b0;
            blank_q       <= 1'b1;
            burst_q       <= 1'b0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            line_q        <= line_d;
            field_q       <= field_d;
            sync_q        <= sync_d;
            blank_q       <= blank_d;
            burst_q       <= burst_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign line        = line_q;
    assign field       = field_q;
    assign sync        = sync_q;
    assign blank       = blank_q;
    assign burst       = burst_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
